// File: rtl/life_sim_scheduler.sv
// Game of Life sequencer: issues generation starts (run/step), counts completed
// generations and serialises cell edits between generations. Field select: 0 = A, 1 = B.
module life_sim_scheduler #(
  parameter int FIELD_W    = 4,
  parameter int FIELD_H    = 3,
  parameter int PERIOD_W   = 24,
  parameter int GEN_W      = 16,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic [PERIOD_W-1:0]   i_period,
  input  logic                  i_edit_req,
  input  logic [X_ADR_SIZE-1:0] i_edit_x,
  input  logic [Y_ADR_SIZE-1:0] i_edit_y,
  input  logic                  i_edit_val,
  input  logic                  i_is_simulating,
  input  logic                  i_cur_read_field,
  output logic                  o_go,
  output logic                  o_edit_ack,
  output logic                  o_wr_en,
  output logic [X_ADR_SIZE-1:0] o_wr_x,
  output logic [Y_ADR_SIZE-1:0] o_wr_y,
  output logic                  o_wr_val,
  output logic                  o_wr_field,
  output logic                  o_gen_done,
  output logic [GEN_W-1:0]      o_gen_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  typedef enum logic [2:0] {IDLE, EDIT, GO, WAIT_SIM, SIM, DONE} state_t;

  localparam logic [31:0] FIELD_W_U = 32'(FIELD_W);
  localparam logic [31:0] FIELD_H_U = 32'(FIELD_H);

  state_t              state, state_nxt;
  logic                pending_step;
  logic [PERIOD_W-1:0] period_cnt;
  logic [1:0]          wait_cnt;
  logic [PERIOD_W:0]   period_need, period_since;
  logic                period_ok, run_ok, edit_ok, timeout;

  // period_cnt is cleared at the end of the GO cycle, so a GO decided at the
  // end of cycle M-1 lands period_cnt+2 cycles after the previous GO.
  always_comb begin
    period_need  = (i_period == '0) ? (PERIOD_W+1)'(1) : {1'b0, i_period};
    period_since = {1'b0, period_cnt} + (PERIOD_W+1)'(2);
    period_ok    = (period_since >= period_need);
    run_ok       = i_run && period_ok;
    edit_ok      = (32'(i_edit_x) < FIELD_W_U) && (32'(i_edit_y) < FIELD_H_U);
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (i_edit_req)        state_nxt = EDIT;
        else if (pending_step) state_nxt = GO;
        else if (run_ok)       state_nxt = GO;
      end
      // The edit being acked is still held, so skip straight to a due GO.
      EDIT:     state_nxt = (pending_step || run_ok) ? GO : IDLE;
      GO:       state_nxt = WAIT_SIM;
      WAIT_SIM: begin
        if (i_is_simulating) begin
          state_nxt = SIM;
        end else if (wait_cnt == 2'd2) begin
          state_nxt = IDLE;
          timeout   = 1'b1;
        end
      end
      SIM:      if (!i_is_simulating) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending_step <= 1'b0;
      period_cnt   <= '0;
      wait_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (i_run)              pending_step <= 1'b0;
      else if (i_step)        pending_step <= 1'b1;
      else if (state == GO)   pending_step <= 1'b0;
      if (state == GO)        period_cnt <= '0;
      else if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_W'(1);
      wait_cnt <= (state == WAIT_SIM) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_go       <= 1'b0;
      o_edit_ack <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_x     <= '0;
      o_wr_y     <= '0;
      o_wr_val   <= 1'b0;
      o_wr_field <= 1'b0;
      o_gen_done <= 1'b0;
      o_gen_cnt  <= '0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_go       <= (state_nxt == GO);
      o_edit_ack <= (state_nxt == EDIT);
      o_wr_en    <= (state_nxt == EDIT) && edit_ok;
      o_gen_done <= (state_nxt == DONE);
      o_busy     <= (state_nxt != IDLE);
      if (state_nxt == EDIT) begin
        o_wr_x     <= i_edit_x;
        o_wr_y     <= i_edit_y;
        o_wr_val   <= i_edit_val;
        o_wr_field <= i_cur_read_field;
      end
      if (state_nxt == DONE) o_gen_cnt <= o_gen_cnt + GEN_W'(1);
      if (timeout)           o_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_life_sim_scheduler.sv
// Directed bench for life_sim_scheduler with a 4x3 mock iterator.
module tb_life_sim_scheduler;

  localparam int WH = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, step = 1'b0;
  logic [23:0] period = '0;
  logic        edit_req = 1'b0;
  logic [2:0]  edit_x = '0;
  logic [1:0]  edit_y = '0;
  logic        edit_val = 1'b0;
  logic        is_sim;
  logic        cur_field = 1'b0;
  logic        go, edit_ack, wr_en, wr_val, wr_field, gen_done, busy, err;
  logic [2:0]  wr_x;
  logic [1:0]  wr_y;
  logic [15:0] gen_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sim_left = 0;
  bit mock_dead = 1'b0;

  life_sim_scheduler #(
    .FIELD_W(4), .FIELD_H(3), .PERIOD_W(24), .GEN_W(16),
    .X_ADR_SIZE(3), .Y_ADR_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .i_step(step), .i_period(period),
    .i_edit_req(edit_req), .i_edit_x(edit_x), .i_edit_y(edit_y), .i_edit_val(edit_val),
    .i_is_simulating(is_sim), .i_cur_read_field(cur_field),
    .o_go(go), .o_edit_ack(edit_ack), .o_wr_en(wr_en), .o_wr_x(wr_x), .o_wr_y(wr_y),
    .o_wr_val(wr_val), .o_wr_field(wr_field), .o_gen_done(gen_done),
    .o_gen_cnt(gen_cnt), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock iterator: busy for WH cycles starting the cycle after o_go.
  assign is_sim = (sim_left != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 sim_left <= 0;
    else if (go && !mock_dead)  sim_left <= WH;
    else if (sim_left != 0)     sim_left <= sim_left - 1;
  end

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; period = '0; edit_req = 1'b0;
    edit_x = '0; edit_y = '0; edit_val = 1'b0; cur_field = 1'b0; mock_dead = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // sel: 0 = o_go, 1 = o_gen_done, 2 = o_edit_ack. Returns at the negedge it is seen.
  task automatic wait_sig(input int sel, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && go) || (sel == 1 && gen_done) || (sel == 2 && edit_ack)) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    apply_reset();
    outs = {go, edit_ack, wr_en, wr_val, wr_field, gen_done, busy, err, 24'(wr_x), 24'(wr_y)};
    checks++;
    if (outs !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", outs);
    end
    checks++;
    if (gen_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_gen_cnt: got %0d required 0", gen_cnt);
    end
  endtask

  task automatic test_run_period0();
    bit f; int t0;
    apply_reset();
    period = 0; run = 1'b1;
    wait_sig(0, 10, f);
    t0 = cyc;
    checks++;
    if (!f) begin errors++; $display("FAIL p0_first_go: got none required pulse"); end
    for (int g = 1; g <= 3; g++) begin
      wait_sig(1, 30, f);
      checks++;
      if (!f || cyc != t0 + 14 || gen_cnt !== 16'(g)) begin
        errors++;
        $display("FAIL p0_done%0d: got found=%0d at +%0d cnt=%0d required at +14 cnt=%0d",
                 g, f, cyc - t0, gen_cnt, g);
      end
      if (g == 3) run = 1'b0;
      else begin
        wait_sig(0, 30, f);
        checks++;
        if (!f || cyc - t0 != 16) begin
          errors++; $display("FAIL p0_go_spacing: got found=%0d spacing %0d required 16", f, cyc - t0);
        end
        t0 = cyc;
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gen_cnt !== 16'd3) begin
      errors++; $display("FAIL p0_stop: got busy=%0d cnt=%0d required busy=0 cnt=3", busy, gen_cnt);
    end
  endtask

  task automatic test_run_period40();
    bit f; int t0, t1, extra;
    apply_reset();
    period = 40; run = 1'b1;
    wait_sig(0, 60, f);
    t0 = cyc;
    wait_sig(0, 60, f);
    t1 = cyc;
    checks++;
    if (!f || t1 - t0 != 40) begin
      errors++; $display("FAIL p40_spacing: got found=%0d spacing %0d required 40", f, t1 - t0);
    end
    to_cycle(t1 + 5);
    run = 1'b0;
    wait_sig(1, 30, f);
    checks++;
    if (!f || cyc != t1 + 14) begin
      errors++; $display("FAIL p40_drop_done: got found=%0d at +%0d required +14", f, cyc - t1);
    end
    extra = 0;
    repeat (60) begin @(negedge clk); if (go) extra++; end
    checks++;
    if (extra != 0 || gen_cnt !== 16'd2) begin
      errors++; $display("FAIL p40_no_more_go: got %0d go cnt=%0d required 0 go cnt=2", extra, gen_cnt);
    end
  endtask

  task automatic test_step_during_sim();
    bit f; int t0, extra;
    apply_reset();
    period = 0; run = 1'b1;
    wait_sig(0, 10, f);
    t0 = cyc;
    to_cycle(t0 + 3);
    run = 1'b0;
    to_cycle(t0 + 5);
    pulse_step();
    wait_sig(0, 30, f);
    checks++;
    if (!f || cyc != t0 + 16) begin
      errors++; $display("FAIL step_in_sim_go: got found=%0d at +%0d required +16", f, cyc - t0);
    end
    wait_sig(1, 30, f);
    extra = 0;
    repeat (40) begin @(negedge clk); if (go) extra++; end
    checks++;
    if (extra != 0 || gen_cnt !== 16'd2) begin
      errors++; $display("FAIL step_in_sim_once: got %0d go cnt=%0d required 0 go cnt=2", extra, gen_cnt);
    end
  endtask

  task automatic test_two_steps();
    bit f; int c;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      c = cyc;
      pulse_step();
      wait_sig(0, 10, f);
      checks++;
      if (!f || cyc != c + 2) begin
        errors++; $display("FAIL step_latency%0d: got found=%0d at +%0d required +2", k, f, cyc - c);
      end
      wait_sig(1, 30, f);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (gen_cnt !== 16'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL two_steps_cnt: got cnt=%0d busy=%0d required cnt=2 busy=0", gen_cnt, busy);
    end
  endtask

  task automatic test_edit_during_sim();
    bit f; int t0, early;
    apply_reset();
    cur_field = 1'b1;
    pulse_step();
    wait_sig(0, 10, f);
    t0 = cyc;
    to_cycle(t0 + 4);
    edit_req = 1'b1; edit_x = 3'd2; edit_y = 2'd1; edit_val = 1'b1;
    early = 0;
    while (cyc < t0 + 16) begin
      @(negedge clk);
      if (cyc < t0 + 16 && (edit_ack || wr_en)) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL edit_held_early: got %0d early ack/write cycles required 0", early);
    end
    checks++;
    if ({edit_ack, wr_en, wr_x, wr_y, wr_val, wr_field} !== {1'b1, 1'b1, 3'd2, 2'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL edit_after_done: got ack=%0d en=%0d x=%0d y=%0d val=%0d fld=%0d required 1 1 2 1 1 1",
               edit_ack, wr_en, wr_x, wr_y, wr_val, wr_field);
    end
    edit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (edit_ack !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL edit_one_cycle: got ack=%0d en=%0d required 0 0", edit_ack, wr_en);
    end
  endtask

  task automatic test_edit_bounds_and_step();
    int c; bit f;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      c = cyc;
      edit_req = 1'b1; edit_val = 1'b1;
      edit_x = (k == 0) ? 3'd5 : 3'd0;
      edit_y = (k == 0) ? 2'd0 : 2'd3;
      @(negedge clk);
      checks++;
      if (cyc != c + 1 || edit_ack !== 1'b1 || wr_en !== 1'b0) begin
        errors++; $display("FAIL edit_oob%0d: got ack=%0d en=%0d at +%0d required ack=1 en=0 at +1",
                           k, edit_ack, wr_en, cyc - c);
      end
      edit_req = 1'b0;
      repeat (2) @(negedge clk);
    end
    c = cyc;
    edit_req = 1'b1; edit_x = 3'd3; edit_y = 2'd2; edit_val = 1'b0; cur_field = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if ({edit_ack, wr_en, wr_x, wr_y, wr_val, go} !== {1'b1, 1'b1, 3'd3, 2'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL edit_before_go: got ack=%0d en=%0d x=%0d y=%0d val=%0d go=%0d required 1 1 3 2 0 0",
                         edit_ack, wr_en, wr_x, wr_y, wr_val, go);
    end
    edit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (go !== 1'b1 || edit_ack !== 1'b0) begin
      errors++; $display("FAIL go_after_edit: got go=%0d ack=%0d at +%0d required go=1 ack=0 at +2",
                         go, edit_ack, cyc - c);
    end
    wait_sig(1, 30, f);
  endtask

  task automatic test_timeout_and_reset();
    bit f; int t0;
    apply_reset();
    mock_dead = 1'b1;
    pulse_step();
    wait_sig(0, 10, f);
    t0 = cyc;
    to_cycle(t0 + 3);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got err=%0d busy=%0d required err=0 busy=1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err: got err=%0d busy=%0d required err=1 busy=0", err, busy);
    end
    mock_dead = 1'b0;
    pulse_step();
    wait_sig(0, 10, f);
    t0 = cyc;
    to_cycle(t0 + 5);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || is_sim !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got err=%0d busy=%0d sim=%0d required 1 1 1", err, busy, is_sim);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({go, edit_ack, wr_en, gen_done, busy, err} !== 6'd0 || gen_cnt !== 16'd0) begin
      errors++; $display("FAIL async_reset: got go=%0d ack=%0d en=%0d done=%0d busy=%0d err=%0d cnt=%0d required all 0",
                         go, edit_ack, wr_en, gen_done, busy, err, gen_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gen_cnt !== 16'd0 || err !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%0d cnt=%0d err=%0d required 0 0 0", busy, gen_cnt, err);
    end
  endtask

  initial begin
    test_reset();
    test_run_period0();
    test_run_period40();
    test_step_during_sim();
    test_two_steps();
    test_edit_during_sim();
    test_edit_bounds_and_step();
    test_timeout_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
